// File: rtl/turn_sequencer.sv
// Turn controller for the two-player 4x4 line game: cursor, claims, win/draw detection.
// Optional per-turn time limit is compiled in with `define TURN_TIMEOUT_EN.
module turn_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        move,
  input  logic        select,
  output logic [31:0] board,
  output logic [3:0]  cursor,
  output logic        player,
  output logic [1:0]  state,
  output logic [4:0]  moves,
  output logic [1:0]  winner,
  output logic        err,
  output logic        timeout
);

  typedef enum logic [1:0] {
    PLAY  = 2'b00,
    CHECK = 2'b01,
    WIN   = 2'b10,
    DRAW  = 2'b11
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [31:0] board_r, board_nxt_s;
  logic [3:0]  cursor_r, cursor_nxt_s;
  logic        player_r, player_nxt_s;
  logic [4:0]  moves_r, moves_nxt_s;
  logic [1:0]  winner_r, winner_nxt_s;
  logic        err_r, err_nxt_s;
  logic        timeout_r, timeout_nxt_s;
  logic        move_q_r, select_q_r;
  logic        move_edge_s, sel_edge_s;
  logic [1:0]  cell_s, mover_code_s;
  logic        expiry_s;

  // True when any row, column or diagonal is fully owned by code.
  function automatic logic line_won(input logic [31:0] b, input logic [1:0] code);
    logic hit;
    hit = 1'b0;
    for (int r = 0; r < 4; r++) begin
      hit = hit | (b[8*r +: 8] == {4{code}});
    end
    for (int c = 0; c < 4; c++) begin
      hit = hit | ((b[2*c +: 2] == code) && (b[2*c+8 +: 2] == code) &&
                   (b[2*c+16 +: 2] == code) && (b[2*c+24 +: 2] == code));
    end
    hit = hit | ((b[1:0] == code) && (b[11:10] == code) &&
                 (b[21:20] == code) && (b[31:30] == code));
    hit = hit | ((b[7:6] == code) && (b[13:12] == code) &&
                 (b[19:18] == code) && (b[25:24] == code));
    return hit;
  endfunction

  assign move_edge_s  = move & ~move_q_r;
  assign sel_edge_s   = select & ~select_q_r;
  assign cell_s       = board_r[{cursor_r, 1'b0} +: 2];
  assign mover_code_s = player_r ? 2'b10 : 2'b01;

`ifdef TURN_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tcnt_r, tcnt_nxt_s;

  // Turn timer: runs only in PLAY, so every entry into PLAY starts from zero.
  always_comb begin
    expiry_s   = 1'b0;
    tcnt_nxt_s = '0;
    if (state_r == PLAY) begin
      expiry_s = ~sel_edge_s && (tcnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
      if (expiry_s) begin
        tcnt_nxt_s = '0;
      end else begin
        tcnt_nxt_s = tcnt_r + CNT_W'(1);
      end
    end else begin
      tcnt_nxt_s = '0;
    end
  end

  // Turn timer register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt_r <= '0;
    end else begin
      tcnt_r <= tcnt_nxt_s;
    end
  end
`else
  assign expiry_s = 1'b0;
`endif

  // Next-state and next-output logic for the game FSM.
  always_comb begin
    state_nxt_s   = state_r;
    board_nxt_s   = board_r;
    cursor_nxt_s  = cursor_r;
    player_nxt_s  = player_r;
    moves_nxt_s   = moves_r;
    winner_nxt_s  = winner_r;
    err_nxt_s     = 1'b0;
    timeout_nxt_s = 1'b0;
    case (state_r)
      PLAY: begin
        // Select outranks move; a move edge in the same cycle is dropped.
        if (sel_edge_s) begin
          if (cell_s == 2'b00) begin
            board_nxt_s[{cursor_r, 1'b0} +: 2] = mover_code_s;
            moves_nxt_s = moves_r + 5'd1;
            state_nxt_s = CHECK;
          end else begin
            err_nxt_s = 1'b1;
          end
        end else if (move_edge_s) begin
          cursor_nxt_s = cursor_r + 4'd1;
        end else begin
          cursor_nxt_s = cursor_r;
        end
        if (expiry_s) begin
          player_nxt_s  = ~player_r;
          timeout_nxt_s = 1'b1;
        end else begin
          player_nxt_s  = player_r;
        end
      end
      CHECK: begin
        if (line_won(board_r, mover_code_s)) begin
          state_nxt_s  = WIN;
          winner_nxt_s = mover_code_s;
        end else if (moves_r == 5'd16) begin
          state_nxt_s = DRAW;
        end else begin
          state_nxt_s  = PLAY;
          player_nxt_s = ~player_r;
        end
      end
      WIN, DRAW: begin
        if (sel_edge_s) begin
          state_nxt_s  = PLAY;
          board_nxt_s  = 32'd0;
          cursor_nxt_s = 4'd0;
          player_nxt_s = 1'b0;
          moves_nxt_s  = 5'd0;
          winner_nxt_s = 2'b00;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = PLAY;
      end
    endcase
  end

  // Game state registers and input edge-detect copies.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= PLAY;
      board_r    <= 32'd0;
      cursor_r   <= 4'd0;
      player_r   <= 1'b0;
      moves_r    <= 5'd0;
      winner_r   <= 2'b00;
      err_r      <= 1'b0;
      timeout_r  <= 1'b0;
      move_q_r   <= 1'b0;
      select_q_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      board_r    <= board_nxt_s;
      cursor_r   <= cursor_nxt_s;
      player_r   <= player_nxt_s;
      moves_r    <= moves_nxt_s;
      winner_r   <= winner_nxt_s;
      err_r      <= err_nxt_s;
      timeout_r  <= timeout_nxt_s;
      move_q_r   <= move;
      select_q_r <= select;
    end
  end

  assign board   = board_r;
  assign cursor  = cursor_r;
  assign player  = player_r;
  assign state   = state_r;
  assign moves   = moves_r;
  assign winner  = winner_r;
  assign err     = err_r;
  assign timeout = timeout_r;

endmodule

// File: tb/tb_turn_sequencer.sv
// Scoreboard bench for turn_sequencer: a cell-array game model predicts every
// cycle's outputs; a monitor process compares them as the DUT presents them.
module tb_turn_sequencer;

  localparam int TC = 8;
  localparam int ST_PLAY = 0, ST_CHECK = 1, ST_WIN = 2, ST_DRAW = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        move = 1'b0;
  logic        select = 1'b0;
  logic [31:0] board;
  logic [3:0]  cursor;
  logic        player;
  logic [1:0]  state;
  logic [4:0]  moves;
  logic [1:0]  winner;
  logic        err;
  logic        timeout;

  turn_sequencer #(.TIMEOUT_CYCLES(TC)) dut (
    .clk(clk), .rst(rst), .move(move), .select(select),
    .board(board), .cursor(cursor), .player(player), .state(state),
    .moves(moves), .winner(winner), .err(err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] board;
    logic [3:0]  cursor;
    logic        player;
    logic [1:0]  state;
    logic [4:0]  moves;
    logic [1:0]  winner;
    logic        err;
    logic        timeout;
  } snap_t;

  typedef struct {
    int    cyc;
    snap_t s;
  } exp_t;

  exp_t expq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference game: cells hold 0 empty, 1 player 1, 2 player 2.
  int cells[16];
  int m_cur, m_pl, m_moves, m_st, m_win, m_tcnt;
  bit m_err, m_to, m_mq, m_sq;

  int lines[10][4] = '{
    '{0, 1, 2, 3}, '{4, 5, 6, 7}, '{8, 9, 10, 11}, '{12, 13, 14, 15},
    '{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
    '{0, 5, 10, 15}, '{3, 6, 9, 12}
  };
  int win_order[7]   = '{0, 4, 1, 5, 2, 6, 3};
  int draw_order[16] = '{0, 2, 1, 3, 6, 4, 7, 5, 8, 10, 9, 11, 14, 12, 15, 13};

  task automatic model_reset();
    foreach (cells[i]) cells[i] = 0;
    m_cur = 0; m_pl = 0; m_moves = 0; m_st = ST_PLAY; m_win = 0; m_tcnt = 0;
    m_err = 0; m_to = 0; m_mq = 0; m_sq = 0;
  endtask

  task automatic model_step(input bit m, input bit s);
    bit me, se, won;
    int code;
    me = m && !m_mq;
    se = s && !m_sq;
    m_mq = m;
    m_sq = s;
    m_err = 0;
    m_to = 0;
    case (m_st)
      ST_PLAY: begin
        if (se) begin
          if (cells[m_cur] == 0) begin
            cells[m_cur] = m_pl + 1;
            m_moves++;
            m_st = ST_CHECK;
          end else begin
            m_err = 1;
          end
        end else if (me) begin
          m_cur = (m_cur + 1) % 16;
        end
`ifdef TURN_TIMEOUT_EN
        if (!se && m_tcnt == TC - 1) begin
          m_pl ^= 1;
          m_to = 1;
          m_tcnt = 0;
        end else begin
          m_tcnt++;
        end
`endif
      end
      ST_CHECK: begin
        code = m_pl + 1;
        won = 0;
        for (int l = 0; l < 10; l++) begin
          if (cells[lines[l][0]] == code && cells[lines[l][1]] == code &&
              cells[lines[l][2]] == code && cells[lines[l][3]] == code)
            won = 1;
        end
        m_tcnt = 0;
        if (won) begin
          m_st = ST_WIN;
          m_win = code;
        end else if (m_moves == 16) begin
          m_st = ST_DRAW;
        end else begin
          m_st = ST_PLAY;
          m_pl ^= 1;
        end
      end
      default: begin
        m_tcnt = 0;
        if (se) begin
          foreach (cells[i]) cells[i] = 0;
          m_cur = 0; m_pl = 0; m_moves = 0; m_win = 0; m_st = ST_PLAY;
        end
      end
    endcase
  endtask

  function automatic snap_t model_snap();
    snap_t r;
    r.board = 32'd0;
    for (int i = 0; i < 16; i++) r.board[2*i +: 2] = 2'(cells[i]);
    r.cursor  = 4'(m_cur);
    r.player  = 1'(m_pl);
    r.state   = 2'(m_st);
    r.moves   = 5'(m_moves);
    r.winner  = 2'(m_win);
    r.err     = m_err;
    r.timeout = m_to;
    return r;
  endfunction

  task automatic push(input int tag);
    exp_t e;
    e.cyc = tag;
    e.s = model_snap();
    expq.push_back(e);
  endtask

  task automatic step(input bit m, input bit s);
    @(posedge clk);
    #1;
    move = m;
    select = s;
    model_step(m, s);
    push(cyc + 1);
  endtask

  task automatic do_reset(input int n);
    int base;
    @(posedge clk);
    #4;
    rst = 1'b0;
    move = 1'b0;
    select = 1'b0;
    model_reset();
    base = cyc;
    for (int k = 1; k <= n; k++) push(base + k);
    repeat (n) @(posedge clk);
    #4;
    rst = 1'b1;
    model_step(1'b0, 1'b0);
    push(cyc + 1);
  endtask

  task automatic claim_at(input int target);
    int guard;
    guard = 0;
    while (m_cur != target && guard < 32) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      guard++;
    end
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
  endtask

  // Monitor: compare every expectation due at this cycle, away from the edge.
  initial begin
    exp_t  e;
    snap_t act;
    forever begin
      @(posedge clk);
      cyc++;
      #3;
      while (expq.size() > 0 && expq[0].cyc <= cyc) begin
        e = expq.pop_front();
        act = {board, cursor, player, state, moves, winner, err, timeout};
        checks++;
        if (act !== e.s) begin
          errors++;
          $display("FAIL snapshot cyc=%0d got board=%h cur=%0d pl=%0d st=%0d mv=%0d win=%0d err=%0b to=%0b want board=%h cur=%0d pl=%0d st=%0d mv=%0d win=%0d err=%0b to=%0b",
                   cyc, act.board, act.cursor, act.player, act.state, act.moves, act.winner, act.err, act.timeout,
                   e.s.board, e.s.cursor, e.s.player, e.s.state, e.s.moves, e.s.winner, e.s.err, e.s.timeout);
        end
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset(2);

    // 17 cursor pulses wrap 15->0, then a held level steps only once.
    repeat (17) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
    end
    repeat (10) step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // Alternating claims giving player 1 the top row.
    foreach (win_order[i]) claim_at(win_order[i]);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    // Player 2 re-claims player 1's cell 0.
    claim_at(0);
    claim_at(0);

    // Reset with a non-empty board.
    claim_at(5);
    do_reset(3);

    // Full board without a line, then restart.
    foreach (draw_order[i]) claim_at(draw_order[i]);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    // Idle turn: expires only when the timer is built.
    repeat (100) step(1'b0, 1'b0);

    // Same-cycle move and select edges.
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0);
    end

    repeat (3) @(posedge clk);
    #4;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations got %0d want 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
